l1i_cache: RTL
==============

# l1i_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the memory controller's L1i port. Hits return the instruction combinationally in the same cycle. Misses stall fetch while a full line is fetched word-by-word from the controller's ROM path. During a fill the cache honours the controller's `stall_l1i` back-pressure and re-issues any word whose request was not serviced.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_address`  in  32  byte address of the fetch; bits [1:0] ignored.
- `cpu_read`  in  1  fetch request this cycle.
- `flush`  in  1  invalidate all lines; honoured only in IDLE.
- `cpu_data`  out  32  instruction word; valid when `cpu_read && !cpu_stall`.
- `cpu_stall`  out  1  fetch must hold `cpu_address` and retry.
- `mem_address`  out  32  word-aligned address to the controller's `l1i_address` input.
- `mem_data`  in  32  controller's `l1i_output_data`, registered one cycle after the address.
- `mem_stall`  in  1  controller's `stall_l1i`; request in this cycle is not serviced.
- `hit_count`  out  32  hit counter (see Configuration).
- `miss_count`  out  32  miss counter (see Configuration).

## Operation
- Address split:
  - offset = `cpu_address[1+log2(WORDS_PER_LINE):2]`.
  - index = next log2(LINES) bits.
  - tag = the remaining upper bits.
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words.
- Hit: state IDLE, `cpu_read`, line valid, tag equal. `cpu_data` is the selected word, `cpu_stall=0`.
- `cpu_stall = (cpu_read && !hit) || state != IDLE`.
- When `cpu_read=0`, `cpu_data` is don't-care; the bench must not check it.
- FSM states:
  - IDLE: on a miss, latch the line base address (offset zeroed) and the index/tag, clear `issue_ctr` and `capture_ctr`, go to FILL. A `flush` in IDLE clears every valid bit in one cycle; the cycle with `flush` high still services a hit against the pre-flush state.
  - FILL, issue side: drive `mem_address = base + 4*issue_ctr` while `issue_ctr < WORDS_PER_LINE`. If `mem_stall=0`, set `pending_valid=1`, set `pending_idx=issue_ctr`, and increment `issue_ctr`. Otherwise set `pending_valid=0` and do not advance.
  - FILL, capture side: if `pending_valid`, write `mem_data` into word `pending_idx` of the target line and increment `capture_ctr`.
  - FILL exit: when the capture of word WORDS_PER_LINE-1 occurs, write the tag, set valid, and go to IDLE. The retried fetch then hits.
- The target line's valid bit is cleared on entry to FILL, so a partially filled line is never visible.
- `flush` during FILL is ignored.
- Reset (including mid-FILL):
  - all valid bits cleared, state IDLE, counters and `pending_valid` cleared.
  - `mem_address=0`, `cpu_stall` follows its combinational equation (1 if `cpu_read`), counters 0.
  - Data and tag arrays are not reset.
- Conflict: a miss whose index holds a different valid tag overwrites that line.

## Timing
- Hit: 0-cycle latency; data valid in the same cycle as `cpu_read`.
- Miss with `mem_stall` held low:
  - cycle 0: miss detected in IDLE.
  - cycles 1..W: issue words 0..W-1.
  - cycles 2..W+1: capture words 0..W-1.
  - cycle W+2: IDLE, hit.
- Miss penalty is W+2 cycles of `cpu_stall` (6 for W=4). Each stalled cycle during FILL adds exactly one cycle.
- `mem_stall` is sampled only in FILL; outside FILL it has no effect.
- `mem_address` is registered: it changes only at a clock edge and holds its last value in IDLE.

## Configuration
- Macro: `L1I_CACHE_STATS_EN`.
- Defined:
  - `hit_count` increments on every IDLE cycle with a hit.
  - `miss_count` increments on every IDLE→FILL transition.
  - Both are 32-bit, wrap at 2^32, and clear on `reset`.
- Undefined: no counter logic is synthesised; both outputs are tied to 0.

## Test plan
- Cold miss at 0x0000_0040, `mem_stall=0`, ROM word at addr A = A:
  - `cpu_stall` high for exactly 6 cycles.
  - `mem_address` sequence 0x40, 0x44, 0x48, 0x4C.
  - Then `cpu_data=0x40`.
  - Fetches 0x44/0x48/0x4C hit with 0 stall.
- Same miss with `mem_stall` high in cycles 2 and 3:
  - 0x44 is issued three times.
  - Penalty is 8 cycles; all four captured words are correct.
- Conflict: fill 0x40, then fetch 0x40 + LINES*16 (0x140):
  - 0x140 misses and refills the line.
  - A subsequent fetch of 0x40 misses again.
- Flush:
  - after the fill of 0x40, pulse `flush` in IDLE; the next fetch of 0x40 misses.
  - `flush` asserted during FILL is ignored and the fill completes.
- Reset mid-FILL after two captures:
  - state IDLE, `mem_address=0`.
  - the next fetch of 0x40 misses and refills fully.
- With `L1I_CACHE_STATS_EN` defined: 1 miss + 3 hits give `miss_count=1`, `hit_count=3`. Undefined: both read 0.

Source files
------------

// File: rtl/l1i_cache.sv
// l1i_cache: direct-mapped, read-only instruction cache between the fetch stage
// and the memory controller's L1i ROM port.
//
// Hits return data combinationally in the same cycle. A miss stalls fetch
// while the full line is fetched word-by-word. Words whose request met
// mem_stall are re-issued.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   cpu_address, cpu_read   fetch request (byte address, bits [1:0] ignored)
//   flush                   invalidate all lines (IDLE only)
//   cpu_data, cpu_stall     combinational fetch response
//   mem_address             registered word address to controller
//   mem_data, mem_stall     controller read data (1-cycle latency), back-pressure
//   hit_count, miss_count   statistics counters
//
// Optional feature: define L1I_CACHE_STATS_EN to build the hit/miss counters.
// Without it, hit_count and miss_count are tied to zero.
module l1i_cache #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        flush,
  output logic [31:0] cpu_data,
  output logic        cpu_stall,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic        mem_stall,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam int unsigned LB_W  = 30 - OFF_W;
  localparam int unsigned CTR_W = OFF_W + 1;

  typedef enum logic [0:0] {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS_PER_LINE];

  logic [LB_W-1:0]    base_q;
  logic [IDX_W-1:0]   fill_idx_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [CTR_W-1:0]   issue_ctr_q;
  logic [CTR_W-1:0]   capture_ctr_q;
  logic               pending_valid_q;
  logic [OFF_W-1:0]   pending_idx_q;

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               start_fill;
  logic               issue_active;
  logic               issue_fire;
  logic               capture_we;
  logic               last_capture;
  logic [CTR_W-1:0]   next_word;
  logic               unused_addr_bits;

  // Address decode and hit detection
  assign req_off          = cpu_address[2 +: OFF_W];
  assign req_idx          = cpu_address[2 + OFF_W +: IDX_W];
  assign req_tag          = cpu_address[31 -: TAG_W];
  assign unused_addr_bits = ^cpu_address[1:0];

  assign hit       = (state_q == IDLE) && cpu_read && valid_q[req_idx] &&
                     (tag_q[req_idx] == req_tag);
  assign cpu_stall = (cpu_read && !hit) || (state_q != IDLE);
  assign cpu_data  = data_q[req_idx][req_off];
  assign next_word = issue_ctr_q + CTR_W'(1);

  // Next-state and fill control
  always_comb begin
    state_d      = state_q;
    start_fill   = 1'b0;
    issue_active = 1'b0;
    issue_fire   = 1'b0;
    capture_we   = 1'b0;
    last_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_read && !hit) begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        issue_active = (issue_ctr_q < CTR_W'(WORDS_PER_LINE));
        issue_fire   = issue_active && !mem_stall;
        capture_we   = pending_valid_q;
        if (pending_valid_q && (capture_ctr_q == CTR_W'(WORDS_PER_LINE - 1))) begin
          last_capture = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, valid bits, fill bookkeeping and the registered memory address
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      base_q          <= '0;
      fill_idx_q      <= '0;
      fill_tag_q      <= '0;
      issue_ctr_q     <= '0;
      capture_ctr_q   <= '0;
      pending_valid_q <= 1'b0;
      pending_idx_q   <= '0;
      mem_address     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && flush) valid_q <= '0;
      if (start_fill) begin
        base_q          <= cpu_address[31 -: LB_W];
        fill_idx_q      <= req_idx;
        fill_tag_q      <= req_tag;
        issue_ctr_q     <= '0;
        capture_ctr_q   <= '0;
        pending_valid_q <= 1'b0;
        valid_q[req_idx] <= 1'b0;
        mem_address     <= {cpu_address[31 -: LB_W], (OFF_W + 2)'(0)};
      end
      if (state_q == FILL) begin
        // A stalled request leaves nothing in flight for the next cycle
        pending_valid_q <= issue_fire;
        if (issue_fire) begin
          pending_idx_q <= issue_ctr_q[OFF_W-1:0];
          issue_ctr_q   <= next_word;
          // Hold the last word's address once the line is fully issued
          if (next_word < CTR_W'(WORDS_PER_LINE))
            mem_address <= {base_q, next_word[OFF_W-1:0], 2'b00};
        end
        if (capture_we) capture_ctr_q <= capture_ctr_q + CTR_W'(1);
        if (last_capture) valid_q[fill_idx_q] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset
  always_ff @(posedge clock) begin
    if (!reset && capture_we) data_q[fill_idx_q][pending_idx_q] <= mem_data;
    if (!reset && last_capture) tag_q[fill_idx_q] <= fill_tag_q;
  end

`ifdef L1I_CACHE_STATS_EN
  logic [31:0] hit_ctr_q;
  logic [31:0] miss_ctr_q;

  // Statistics counters, wrapping at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_ctr_q  <= '0;
      miss_ctr_q <= '0;
    end else begin
      if (hit)        hit_ctr_q  <= hit_ctr_q + 32'd1;
      if (start_fill) miss_ctr_q <= miss_ctr_q + 32'd1;
    end
  end

  assign hit_count  = hit_ctr_q;
  assign miss_count = miss_ctr_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
